// File: rtl/qe_pkg.sv
// Shared types and constants for the QL expansion bus to W5300 bridge.
package qe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    ACK    = 2'd2,
    RECOV  = 2'd3
  } state_t;

  localparam logic [5:0] CARD_BASE_DEF  = 6'h32;
  localparam logic [3:0] WIZ_OFFSET_DEF = 4'h0;
  localparam logic [3:0] RST_OFFSET_DEF = 4'h4;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/qe_wiz_reset_gen.sv
// W5300 hardware reset pulse: fires once after reset release and again on every trigger.
module qe_wiz_reset_gen
  import qe_pkg::*;
#(
  parameter int RESET_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic wizrstl
);

  localparam int RST_W = cnt_width(RESET_CYCLES);

  logic [RST_W-1:0] cnt;
  logic             por;

  // The first clock after reset release reloads the counter, so power-up and a register write give the same pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      por     <= 1'b1;
      wizrstl <= 1'b0;
    end else if (por || trigger) begin
      por     <= 1'b0;
      cnt     <= RST_W'(RESET_CYCLES);
      wizrstl <= 1'b0;
    end else if (cnt != '0) begin
      cnt     <= cnt - RST_W'(1);
      wizrstl <= (cnt == RST_W'(1));
    end
  end

endmodule

// File: rtl/qe_bus_controller.sv
// QL expansion bus to W5300 bridge: strobe synchroniser, card window decode and
// the access sequencer that drives the W5300 strobes, DTACK and bus recovery.
module qe_bus_controller
  import qe_pkg::*;
#(
  parameter int                ADDR_W       = 10,
  parameter logic [ADDR_W-5:0] CARD_BASE    = CARD_BASE_DEF,
  parameter logic [3:0]        WIZ_OFFSET   = WIZ_OFFSET_DEF,
  parameter logic [3:0]        RST_OFFSET   = RST_OFFSET_DEF,
  parameter int                WAIT_CYCLES  = 3,
  parameter int                RECOV_CYCLES = 2,
  parameter int                RESET_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              asl,
  input  logic              dsl,
  input  logic              rdwl,
  output logic              dtackl,
  output logic              dsmcl,
  output logic              dbenl,
  output logic              dbdir,
  output logic              wizcsl,
  output logic              wizrdl,
  output logic              wizwrl,
  output logic              wizrstl
);

  localparam int CNT_W = cnt_width((WAIT_CYCLES > RECOV_CYCLES) ? WAIT_CYCLES : RECOV_CYCLES);

  logic ds_m, ds_s, as_m, as_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_m <= 1'b1;
      ds_s <= 1'b1;
      as_m <= 1'b1;
      as_s <= 1'b1;
    end else begin
      ds_m <= dsl;
      ds_s <= ds_m;
      as_m <= asl;
      as_s <= as_m;
    end
  end

  logic hit, wiz_hit, rst_hit;

  assign hit     = !as_s && (address[ADDR_W-1:4] == CARD_BASE);
  assign wiz_hit = hit && (address[3:0] == WIZ_OFFSET);
  assign rst_hit = hit && (address[3:0] == RST_OFFSET);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             rd_q, next_rd;
  logic             wiz_q, next_wiz;
  logic             rst_trigger;
  logic             ack_q;
  logic             ack_d, dsmc_d, dben_d, dbdir_d, cs_d, rd_d, wr_d;

  // Access kind is captured on entry to STROBE so the strobes stay steady for the whole cycle.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_rd     = rd_q;
    next_wiz    = wiz_q;
    rst_trigger = 1'b0;
    case (state)
      IDLE: begin
        next_rd  = rdwl;
        next_wiz = wiz_hit && wizrstl;
        if (!ds_s && hit) begin
          next_state  = STROBE;
          next_cnt    = (rst_hit || WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES);
          rst_trigger = rst_hit && !rdwl;
        end
      end
      STROBE: begin
        if (ds_s) begin
          next_state = RECOV;
          next_cnt   = CNT_W'(RECOV_CYCLES - 1);
        end else if (cnt == '0) begin
          next_state = ACK;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        if (ds_s) begin
          next_state = RECOV;
          next_cnt   = CNT_W'(RECOV_CYCLES - 1);
        end
      end
      RECOV: begin
        if (cnt == '0) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase

    ack_d   = 1'b0;
    dsmc_d  = 1'b0;
    dben_d  = 1'b1;
    dbdir_d = 1'b1;
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    if (next_state == STROBE || next_state == ACK) begin
      ack_d   = (next_state == ACK);
      dsmc_d  = 1'b1;
      dben_d  = 1'b0;
      dbdir_d = next_rd;
      if (next_wiz) begin
        cs_d = 1'b0;
        rd_d = !next_rd;
        wr_d = next_rd;
      end
    end
  end

  // Outputs are registered from the next-state decode so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_q   <= 1'b1;
      wiz_q  <= 1'b0;
      ack_q  <= 1'b0;
      dsmcl  <= 1'b0;
      dbenl  <= 1'b1;
      dbdir  <= 1'b1;
      wizcsl <= 1'b1;
      wizrdl <= 1'b1;
      wizwrl <= 1'b1;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      rd_q   <= next_rd;
      wiz_q  <= next_wiz;
      ack_q  <= ack_d;
      dsmcl  <= dsmc_d;
      dbenl  <= dben_d;
      dbdir  <= dbdir_d;
      wizcsl <= cs_d;
      wizrdl <= rd_d;
      wizwrl <= wr_d;
    end
  end

  assign dtackl = ack_q ? 1'b0 : 1'bz;

  qe_wiz_reset_gen #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset_gen (
    .clk     (clk),
    .rst     (rst),
    .trigger (rst_trigger),
    .wizrstl (wizrstl)
  );

endmodule

// File: tb/tb_qe_bus_controller.sv
// Scoreboard bench for qe_bus_controller: stimulus queues timed output snapshots, a monitor checks them.
module tb_qe_bus_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] address = '0;
  logic       asl = 1'b1;
  logic       dsl = 1'b1;
  logic       rdwl = 1'b1;
  wire        dtackl;
  logic       dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl;

  pullup (dtackl);

  qe_bus_controller dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .asl     (asl),
    .dsl     (dsl),
    .rdwl    (rdwl),
    .dtackl  (dtackl),
    .dsmcl   (dsmcl),
    .dbenl   (dbenl),
    .dbdir   (dbdir),
    .wizcsl  (wizcsl),
    .wizrdl  (wizrdl),
    .wizwrl  (wizwrl),
    .wizrstl (wizrstl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot bits: {acking, dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl}
  localparam logic [7:0] S_RSTLOW     = 8'b0011_1110;
  localparam logic [7:0] S_IDLE       = 8'b0011_1111;
  localparam logic [7:0] S_RD_STROBE  = 8'b0101_0011;
  localparam logic [7:0] S_RD_ACK     = 8'b1101_0011;
  localparam logic [7:0] S_WR_STROBE  = 8'b0100_0101;
  localparam logic [7:0] S_WR_ACK     = 8'b1100_0101;
  localparam logic [7:0] S_RW_STROBE  = 8'b0100_1110;
  localparam logic [7:0] S_RW_ACK     = 8'b1100_1110;
  localparam logic [7:0] S_RDX_STROBE = 8'b0101_1110;
  localparam logic [7:0] S_RDX_ACK    = 8'b1101_1110;
  localparam logic [7:0] S_OTH_STROBE = 8'b0101_1111;
  localparam logic [7:0] S_OTH_ACK    = 8'b1101_1111;

  typedef struct {
    int         due;
    logic [7:0] snap;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [7:0] snapshot();
    return {(dtackl === 1'b0), dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl};
  endfunction

  // Expectations are kept sorted by due cycle so overlapping transactions can be queued in any order.
  task automatic check_output(input int due, input logic [7:0] snap, input string name);
    exp_t e;
    int   idx;
    e.due  = due;
    e.snap = snap;
    e.name = name;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > due) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  logic [7:0] prev_snap = S_RSTLOW;

  always @(posedge clk) begin
    logic [7:0] now;
    bit         matched;
    exp_t       e;
    #2;
    now     = snapshot();
    matched = 1'b0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      compared++;
      matched = 1'b1;
      if (e.due != cyc || now !== e.snap) begin
        mismatched++;
        $display("[TB] FAIL %s at cycle %0d (due %0d): got %b, expected %b", e.name, cyc, e.due, now, e.snap);
      end
    end
    if (now !== prev_snap && !matched) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_change at cycle %0d: got %b, expected %b", cyc, now, prev_snap);
    end
    prev_snap = now;
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [9:0] a, input logic rd);
    address = a;
    rdwl    = rd;
    asl     = 1'b0;
    dsl     = 1'b0;
  endtask

  task automatic release_bus();
    asl = 1'b1;
    dsl = 1'b1;
  endtask

  initial begin
    int c0;

    // Power-up: reset released mid-period after cycle 5, first counted edge is 6.
    check_output(2, S_RSTLOW, "reset_state");
    @(negedge clk);
    wait_cycle(5);
    rst = 1'b0;
    check_output(40, S_RSTLOW, "powerup_hold");
    check_output(69, S_RSTLOW, "powerup_last_low");
    check_output(70, S_IDLE, "powerup_release");
    wait_cycle(72);

    // W5300 read at 0x320.
    c0 = cyc;
    apply_stimulus(10'h320, 1'b1);
    check_output(c0 + 3, S_RD_STROBE, "rd_strobe");
    check_output(c0 + 6, S_RD_STROBE, "rd_no_early_ack");
    check_output(c0 + 7, S_RD_ACK, "rd_ack");
    check_output(c0 + 11, S_IDLE, "rd_recov");
    wait_cycle(c0 + 8);
    release_bus();
    wait_cycle(c0 + 14);

    // Reset register write, W5300 read while in reset, then a retrigger.
    c0 = cyc;
    apply_stimulus(10'h324, 1'b0);
    check_output(c0 + 3, S_RW_STROBE, "rstreg_strobe");
    check_output(c0 + 4, S_RW_ACK, "rstreg_ack");
    check_output(c0 + 8, S_RSTLOW, "rstreg_recov");
    wait_cycle(c0 + 5);
    release_bus();
    wait_cycle(c0 + 11);
    apply_stimulus(10'h320, 1'b1);
    check_output(c0 + 14, S_RDX_STROBE, "rd_in_reset_strobe");
    check_output(c0 + 18, S_RDX_ACK, "rd_in_reset_ack");
    check_output(c0 + 22, S_RSTLOW, "rd_in_reset_recov");
    wait_cycle(c0 + 19);
    release_bus();
    wait_cycle(c0 + 30);
    apply_stimulus(10'h324, 1'b0);
    check_output(c0 + 33, S_RW_STROBE, "retrig_strobe");
    check_output(c0 + 34, S_RW_ACK, "retrig_ack");
    check_output(c0 + 38, S_RSTLOW, "retrig_recov");
    check_output(c0 + 67, S_RSTLOW, "retrig_extends");
    check_output(c0 + 96, S_RSTLOW, "retrig_last_low");
    check_output(c0 + 97, S_IDLE, "retrig_release");
    wait_cycle(c0 + 35);
    release_bus();
    wait_cycle(c0 + 99);

    // Cycles outside the card window leave the bus alone.
    c0 = cyc;
    apply_stimulus(10'h310, 1'b1);
    check_output(c0 + 4, S_IDLE, "noncard_310_mid");
    check_output(c0 + 8, S_IDLE, "noncard_310_end");
    wait_cycle(c0 + 8);
    release_bus();
    wait_cycle(c0 + 12);
    c0 = cyc;
    apply_stimulus(10'h120, 1'b0);
    check_output(c0 + 4, S_IDLE, "noncard_120_mid");
    check_output(c0 + 8, S_IDLE, "noncard_120_end");
    wait_cycle(c0 + 8);
    release_bus();
    wait_cycle(c0 + 12);

    // Unused offset inside the window: acknowledged without W5300 strobes.
    c0 = cyc;
    apply_stimulus(10'h328, 1'b1);
    check_output(c0 + 3, S_OTH_STROBE, "other_strobe");
    check_output(c0 + 7, S_OTH_ACK, "other_ack");
    check_output(c0 + 11, S_IDLE, "other_recov");
    wait_cycle(c0 + 8);
    release_bus();
    wait_cycle(c0 + 14);

    // Aborted read, then a back-to-back read that must wait out recovery.
    c0 = cyc;
    apply_stimulus(10'h320, 1'b1);
    check_output(c0 + 3, S_RD_STROBE, "abort_strobe");
    check_output(c0 + 6, S_IDLE, "abort_recov");
    check_output(c0 + 7, S_IDLE, "abort_no_ack");
    check_output(c0 + 9, S_RD_STROBE, "b2b_strobe");
    check_output(c0 + 13, S_RD_ACK, "b2b_ack");
    check_output(c0 + 17, S_IDLE, "b2b_recov");
    wait_cycle(c0 + 3);
    release_bus();
    wait_cycle(c0 + 4);
    apply_stimulus(10'h320, 1'b1);
    wait_cycle(c0 + 14);
    release_bus();
    wait_cycle(c0 + 20);

    // W5300 write.
    c0 = cyc;
    apply_stimulus(10'h320, 1'b0);
    check_output(c0 + 3, S_WR_STROBE, "wr_strobe");
    check_output(c0 + 7, S_WR_ACK, "wr_ack");
    check_output(c0 + 11, S_IDLE, "wr_recov");
    wait_cycle(c0 + 8);
    release_bus();
    wait_cycle(c0 + 14);

    // Reset pulse while acknowledging a read.
    c0 = cyc;
    apply_stimulus(10'h320, 1'b1);
    check_output(c0 + 3, S_RD_STROBE, "rstack_strobe");
    check_output(c0 + 7, S_RD_ACK, "rstack_ack");
    check_output(c0 + 9, S_RSTLOW, "rstack_reset");
    check_output(c0 + 73, S_RSTLOW, "rstack_pulse_last_low");
    check_output(c0 + 74, S_IDLE, "rstack_pulse_release");
    wait_cycle(c0 + 8);
    rst = 1'b1;
    wait_cycle(c0 + 9);
    rst = 1'b0;
    release_bus();
    wait_cycle(c0 + 76);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s never checked: got nothing, expected %b by cycle %0d", e.name, e.snap, e.due);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
